// File: rtl/chu_video_pkg.sv
// chu_video_pkg: shared FSM state type and slot register map
// for the chu video stream cores.
package chu_video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_COUNT   = 2'd2,
        ST_LATCHED = 2'd3
    } coll_state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_THRESH = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_DEBUG  = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;
    localparam int CTRL_HL  = 2;

endpackage

// File: rtl/chu_pix_strobe.sv
// chu_pix_strobe: pixel and frame strobes derived from the
// frame counter position changing between clocks.
module chu_pix_strobe (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [10:0] y,
    output logic        pix_stb,
    output logic        frame_stb
);

    logic [10:0] x_q;
    logic [10:0] y_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x;
            y_q <= y;
        end
    end

    assign pix_stb   = ({x, y} != {x_q, y_q});
    assign frame_stb = pix_stb && (x == '0) && (y == '0);

endmodule

// File: rtl/chu_collision_core.sv
// chu_collision_core: per-frame sprite/obstacle overlap counter with
// debounced collision latch and irq. Option: COLLISION_HIGHLIGHT_EN.
module chu_collision_core
    import chu_video_pkg::*;
#(
    parameter int CD         = 12,
    parameter int KEY_COLOR  = 0,
    parameter int HACT       = 640,
    parameter int VACT       = 480,
    parameter int CNT_W      = 19,
    parameter int DEB_FRAMES = 2
`ifdef COLLISION_HIGHLIGHT_EN
    ,
    parameter logic [CD-1:0] HL_COLOR = 12'hF00
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic          cs,
    input  logic          write,
    input  logic          read,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    input  logic [CD-1:0] si_rgb,
    input  logic [CD-1:0] sp_rgb,
    output logic [CD-1:0] so_rgb,
    output logic          irq
);

    localparam logic [10:0]   HACT_L  = 11'(HACT);
    localparam logic [10:0]   VACT_L  = 11'(VACT);
    localparam logic [CD-1:0] KEY_L   = CD'(KEY_COLOR);
    localparam logic [1:0]    DEB_LIM = 2'(DEB_FRAMES);

    logic             pix_stb;
    logic             frame_stb;
    logic             wr_en;
    logic             wr_ctrl;
    logic             wr_thr;
    logic             clr;
    logic             hit;
    logic             enable;
    logic             hl;
    logic             latched;
    logic [CNT_W-1:0] thresh;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] last_cnt;
    logic [CNT_W-1:0] hit_inc;
    logic [CNT_W-1:0] first_cnt;
    logic [1:0]       deb_cnt;
    logic [1:0]       deb_inc;
    coll_state_t      state;
    logic             unused_ok;

    chu_pix_strobe u_stb (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .pix_stb   (pix_stb),
        .frame_stb (frame_stb)
    );

    assign wr_en   = cs && write && addr[13];
    assign wr_ctrl = wr_en && (addr[1:0] == REG_CTRL);
    assign wr_thr  = wr_en && (addr[1:0] == REG_THRESH);
    assign clr     = wr_ctrl && wr_data[CTRL_CLR];

    assign hit = pix_stb && (x < HACT_L) && (y < VACT_L)
              && (sp_rgb != si_rgb) && (si_rgb != KEY_L);

    assign hit_inc   = (hit && !(&hit_cnt)) ? hit_cnt + 1'b1 : hit_cnt;
    assign first_cnt = {{(CNT_W-1){1'b0}}, hit};
    assign deb_inc   = (&deb_cnt) ? deb_cnt : deb_cnt + 2'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable <= 1'b0;
            thresh <= CNT_W'(1);
        end else begin
            if (wr_ctrl)
                enable <= wr_data[CTRL_EN];
            if (wr_thr)
                thresh <= (wr_data[CNT_W-1:0] == '0) ?
                          CNT_W'(1) : wr_data[CNT_W-1:0];
        end
    end

`ifdef COLLISION_HIGHLIGHT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            hl <= 1'b0;
        else if (wr_ctrl)
            hl <= wr_data[CTRL_HL];
    end

    assign so_rgb = (hl && hit) ? HL_COLOR : sp_rgb;
`else
    assign hl     = 1'b0;
    assign so_rgb = sp_rgb;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            hit_cnt  <= '0;
            last_cnt <= '0;
            deb_cnt  <= '0;
            latched  <= 1'b0;
        end else if (!enable) begin
            state    <= ST_IDLE;
            hit_cnt  <= '0;
            last_cnt <= '0;
            deb_cnt  <= '0;
            latched  <= 1'b0;
        end else if (clr) begin
            // clear beats a same-cycle deciding frame strobe
            state   <= ST_WAIT;
            hit_cnt <= '0;
            deb_cnt <= '0;
            latched <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (frame_stb) begin
                        state   <= ST_COUNT;
                        hit_cnt <= first_cnt;
                    end
                end
                default: begin
                    if (frame_stb) begin
                        last_cnt <= hit_cnt;
                        hit_cnt  <= first_cnt;
                        if (state == ST_COUNT) begin
                            if (hit_cnt >= thresh) begin
                                deb_cnt <= deb_inc;
                                if (deb_inc >= DEB_LIM) begin
                                    state   <= ST_LATCHED;
                                    latched <= 1'b1;
                                end
                            end else begin
                                deb_cnt <= '0;
                            end
                        end
                    end else begin
                        hit_cnt <= hit_inc;
                    end
                end
            endcase
        end
    end

    assign irq = latched;

    always_comb begin
        rd_data = '0;
        unique case (addr[1:0])
            REG_CTRL:   rd_data[2:0]       = {hl, 1'b0, enable};
            REG_THRESH: rd_data[CNT_W-1:0] = thresh;
            REG_STATUS: rd_data[CNT_W:0]   = {last_cnt, latched};
            REG_DEBUG:  rd_data[3:0]       = {deb_cnt, state};
        endcase
    end

    assign unused_ok = ^{read, addr[12:2], wr_data[31:CNT_W]};

endmodule
